// File: rtl/lut_load_ctrl.sv
// lut_load_ctrl: sequences one rectification-LUT load from a byte stream into the coefficient RAM,
// with length checking and a stall watchdog.
module lut_load_ctrl #(
   parameter int LUT_DEPTH = 160,
   parameter int AW        = 8,
   parameter int DW        = 8,
   parameter int TIMEOUT   = 1024,
   parameter int TW        = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_req,
   output logic          src_start,
   input  logic [DW-1:0] ltdata,
   input  logic          ltvalid,
   input  logic          ltlast,
   output logic          ltready,
   input  logic          wr_stall,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [DW-1:0] wr_data,
   output logic          busy,
   output logic          done,
   output logic          lut_ok,
   output logic          err_short,
   output logic          err_long,
   output logic          err_tmo
);
   typedef enum logic [2:0] {IDLE, START, RECV, DRAIN, FIN} state_t;
   state_t state, nxt;
   logic [AW-1:0] cnt;
   logic [TW-1:0] wd;
   logic pending, acc, in_rx, at_end, wd_hit, launch;
   assign in_rx     = state == RECV || state == DRAIN;
   assign ltready   = (state == RECV && !wr_stall) || state == DRAIN;
   assign acc       = ltvalid && ltready;
   assign at_end    = cnt == AW'(LUT_DEPTH - 1);
   assign wd_hit    = in_rx && !acc && wd == TW'(TIMEOUT - 1);
   assign busy      = state != IDLE;
   assign src_start = state == START;
   assign launch    = state == IDLE && (load_req || pending);
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = launch ? START : IDLE;
         START:   nxt = RECV;
         RECV:    nxt = acc ? (ltlast ? FIN : at_end ? DRAIN : RECV) : wd_hit ? FIN : RECV;
         DRAIN:   nxt = (acc && ltlast) || wd_hit ? FIN : DRAIN;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         wd        <= '0;
         pending   <= 1'b0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         done      <= 1'b0;
         lut_ok    <= 1'b0;
         err_short <= 1'b0;
         err_long  <= 1'b0;
         err_tmo   <= 1'b0;
      end else begin
         state   <= nxt;
         done    <= state == FIN;
         wr_en   <= state == RECV && acc;
         pending <= state == IDLE ? 1'b0 : pending || load_req;
         wd      <= (acc || !in_rx) ? '0 : wd + 1'b1;
         if (launch) begin
            cnt       <= '0;
            lut_ok    <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            err_tmo   <= 1'b0;
         end
         if (state == RECV && acc) begin
            cnt     <= cnt + 1'b1;
            wr_addr <= cnt;
            wr_data <= ltdata;
            if (ltlast && !at_end) err_short <= 1'b1;
            if (!ltlast && at_end) err_long <= 1'b1;
         end
         if (wd_hit) err_tmo <= 1'b1;
         if (state == FIN) lut_ok <= !(err_short || err_long || err_tmo);
      end
   end
endmodule

// File: tb/tb_lut_load_ctrl.sv
// tb_lut_load_ctrl: directed bench for lut_load_ctrl; a negedge monitor tallies writes, handshakes and pulses,
// and the main sequence checks them against hand-derived values.
module tb_lut_load_ctrl;
   logic clk = 1'b0, rst = 1'b1, load_req = 1'b0, ltvalid = 1'b0, ltlast = 1'b0, wr_stall = 1'b0;
   logic [7:0] ltdata = '0;
   logic src_start, ltready, wr_en, busy, done, lut_ok, err_short, err_long, err_tmo;
   logic [7:0] wr_addr, wr_data;
   int nvec = 0, nerr = 0, cyc = 0;
   int nwr, ndone, nstart, nacc, nbad_rdy, nbad_addr, done_cyc, acc_cyc, start_cyc, req_cyc;
   int mem [256];

   lut_load_ctrl dut (
      .clk(clk), .rst(rst), .load_req(load_req), .src_start(src_start), .ltdata(ltdata),
      .ltvalid(ltvalid), .ltlast(ltlast), .ltready(ltready), .wr_stall(wr_stall), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .lut_ok(lut_ok),
      .err_short(err_short), .err_long(err_long), .err_tmo(err_tmo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (wr_en) begin
         mem[wr_addr] = int'(wr_data);
         nwr++;
         if (wr_addr > 8'd159) nbad_addr++;
      end
      if (done) begin ndone++; done_cyc = cyc; end
      if (src_start) begin nstart++; start_cyc = cyc; end
      if (ltvalid && ltready) begin nacc++; acc_cyc = cyc; end
      if (wr_stall && ltready) nbad_rdy++;
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clr();
      nwr = 0; ndone = 0; nstart = 0; nacc = 0; nbad_rdy = 0; nbad_addr = 0;
      for (int i = 0; i < 256; i++) mem[i] = -1;
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_req();
      req_cyc = cyc;
      load_req = 1'b1;
      tick(1);
      load_req = 1'b0;
   endtask

   // Presents beats 0..n-1 (data = index); each beat is held until accepted.
   task automatic send(input int n, input int last_at, input bit gaps, input int stall_at,
                       input int stall_len, input bit preq);
      int i = 0, g = 0;
      bit a, stalled = 0;
      while (i < n && g < 20000) begin
         if (i == stall_at && !stalled) begin
            stalled = 1;
            ltvalid = 1'b0;
            tick(stall_len);
         end
         ltvalid  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         wr_stall = gaps ? ($urandom_range(0, 9) < 3) : 1'b0;
         ltdata   = 8'(i);
         ltlast   = i == last_at;
         load_req = preq && (i == 20 || i == 40 || i == 60);
         #1;
         a = ltvalid && ltready;
         @(posedge clk); #1;
         if (a) i++;
         g++;
      end
      ltvalid = 1'b0; ltlast = 1'b0; wr_stall = 1'b0; load_req = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int n0 = ndone, k = 0;
      while (ndone == n0 && k < limit) begin tick(1); k++; end
      chk("done_seen", ndone, n0 + 1);
   endtask

   task automatic chk_mem(input string tag, input int n);
      int bad = 0;
      for (int i = 0; i < n; i++) if (mem[i] != i) bad++;
      chk(tag, bad, 0);
   endtask

   initial begin
      clr();
      tick(3);
      chk("reset_outputs", {src_start, ltready, wr_en, wr_addr, wr_data, busy, done, lut_ok,
                            err_short, err_long, err_tmo}, 0);
      rst = 1'b0;
      tick(2);
      // clean gap-free load
      clr();
      pulse_req();
      send(160, 159, 0, -1, 0, 0);
      wait_done(50);
      chk("t1_latency", done_cyc - req_cyc, 163);
      chk("t1_starts", nstart, 1);
      chk("t1_writes", nwr, 160);
      chk_mem("t1_data", 160);
      chk("t1_addr_range", nbad_addr, 0);
      chk("t1_flags", {lut_ok, err_short, err_long, err_tmo}, 4'b1000);
      tick(5);
      chk("t1_done_once", ndone, 1);
      // random valid gaps and RAM stalls
      clr();
      pulse_req();
      send(160, 159, 1, -1, 0, 0);
      wait_done(50);
      chk("t2_writes", nwr, 160);
      chk_mem("t2_data", 160);
      chk("t2_ready_in_stall", nbad_rdy, 0);
      chk("t2_flags", {lut_ok, err_short, err_long, err_tmo}, 4'b1000);
      // short stream
      clr();
      pulse_req();
      send(100, 99, 0, -1, 0, 0);
      wait_done(50);
      chk("t3_writes", nwr, 100);
      chk_mem("t3_data", 100);
      chk("t3_flags", {lut_ok, err_short, err_long, err_tmo}, 4'b0100);
      // long stream: 5 extra bytes drained without writes
      clr();
      pulse_req();
      send(165, 164, 0, -1, 0, 0);
      wait_done(50);
      chk("t4_writes", nwr, 160);
      chk("t4_accepts", nacc, 165);
      chk("t4_done_after_last", done_cyc - acc_cyc, 2);
      chk("t4_addr_range", nbad_addr, 0);
      chk("t4_flags", {lut_ok, err_short, err_long, err_tmo}, 4'b0010);
      // stall after byte 10: FIN follows the 1024th idle cycle, done one cycle later
      clr();
      pulse_req();
      send(11, -1, 0, -1, 0, 0);
      wait_done(1200);
      chk("t5_tmo_delay", done_cyc - acc_cyc, 1026);
      chk("t5_flags", {lut_ok, err_short, err_long, err_tmo}, 4'b0001);
      // accept on the expiry cycle wins over the watchdog
      clr();
      pulse_req();
      send(160, 159, 0, 11, 1023, 0);
      wait_done(200);
      chk("t5b_writes", nwr, 160);
      chk("t5b_flags", {lut_ok, err_short, err_long, err_tmo}, 4'b1000);
      // three requests mid-load collapse into one extra load
      clr();
      pulse_req();
      send(160, 159, 0, -1, 0, 1);
      wait_done(50);
      tick(1);
      chk("t6_restart_gap", start_cyc - done_cyc, 1);
      chk("t6_starts", nstart, 2);
      send(160, 159, 0, -1, 0, 0);
      wait_done(50);
      tick(20);
      chk("t6_no_third", nstart, 2);
      chk("t6_writes", nwr, 320);
      chk("t6_ok", lut_ok, 1);
      // reset mid-load
      clr();
      pulse_req();
      send(50, -1, 0, -1, 0, 0);
      rst = 1'b1;
      tick(1);
      chk("t6_rst_outputs", {src_start, ltready, wr_en, wr_addr, wr_data, busy, done, lut_ok,
                             err_short, err_long, err_tmo}, 0);
      rst = 1'b0;
      tick(30);
      chk("t6_rst_no_done", ndone, 0);
      chk("t6_rst_lut_ok", lut_ok, 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
